// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master fixed-priority arbiter for the single-port DMEM.
// Master 0 (CPU) wins ties; master 1 is forced ahead after STARVE_MAX
// consecutive denials. Translates MARS byte addresses to DMEM word indices.
// Optional feature macro: DMEM_ARB_RANGE_CHECK_EN (address range checking
// with a sticky err_addr flag; without it err_addr is tied to 0).
module dmem_arbiter #(
  parameter logic [31:0] ADDR_BASE  = 32'h1001_0000,
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_wena,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wena,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  dm_ena,
  output logic                  dm_wena,
  output logic [DEPTH_LOG2-1:0] dm_addr,
  output logic [31:0]           dm_data_in,
  input  logic [31:0]           dm_data_out,
  output logic                  err_addr
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;
  logic [31:0]      m0_rdata_q, m0_rdata_d;
  logic [31:0]      m1_rdata_q, m1_rdata_d;

  logic        gnt0, gnt1, gnt_any;
  logic        sel_wena;
  logic [31:0] sel_addr, sel_wdata, sel_off;
  logic        oor;

  // Decode the current owner and mux its access onto a common path
  always_comb begin
    gnt0      = (state_q == G0);
    gnt1      = (state_q == G1);
    gnt_any   = gnt0 | gnt1;
    sel_wena  = gnt1 ? m1_wena  : m0_wena;
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    sel_off   = sel_addr - ADDR_BASE;
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic err_q, err_d;

  // Flag a granted access below the base, past the last word, or misaligned
  always_comb begin
    oor = gnt_any &&
          ((sel_addr < ADDR_BASE) ||
           ((sel_off >> (DEPTH_LOG2 + 2)) != 32'd0) ||
           (sel_addr[1:0] != 2'b00));
  end

  // Sticky address-error flag, cleared only by reset
  always_comb begin
    err_d = err_q | oor;
  end

  // Error flag register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_addr = err_q;
`else
  assign oor      = 1'b0;
  assign err_addr = 1'b0;
`endif

  // DMEM pins follow the owner in its grant cycle; all zero when idle
  always_comb begin
    dm_ena     = gnt_any & ~oor;
    dm_wena    = gnt_any & sel_wena & ~oor;
    dm_addr    = gnt_any ? DEPTH_LOG2'(sel_off >> 2) : '0;
    dm_data_in = gnt_any ? sel_wdata : '0;
  end

  // Next owner, starvation count and read-return capture
  always_comb begin
    state_d     = IDLE;
    starve_d    = '0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    if (m1_req && (starve_q == STARVE_LIM)) begin
      state_d = G1;
    end else if (m0_req) begin
      state_d = G0;
    end else if (m1_req) begin
      state_d = G1;
    end

    if (m1_req && (state_d != G1)) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + CNT_W'(1);
    end

    if (gnt0 && !m0_wena) begin
      m0_rvalid_d = 1'b1;
      m0_rdata_d  = oor ? 32'h0 : dm_data_out;
    end
    if (gnt1 && !m1_wena) begin
      m1_rvalid_d = 1'b1;
      m1_rdata_d  = oor ? 32'h0 : dm_data_out;
    end
  end

  // State, counter and read-return registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic,
// checked each cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          MAXS = 4;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic        m0_req, m0_wena, m1_req, m1_wena;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_ena, dm_wena, err_addr;
  logic [4:0]  dm_addr;
  logic [31:0] dm_data_in, dm_data_out;

  always #5 clk_in = ~clk_in;

  dmem_arbiter #(
    .ADDR_BASE (BASE),
    .DEPTH_LOG2(5),
    .STARVE_MAX(MAXS)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_wena    (m0_wena),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_wena    (m1_wena),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .dm_ena     (dm_ena),
    .dm_wena    (dm_wena),
    .dm_addr    (dm_addr),
    .dm_data_in (dm_data_in),
    .dm_data_out(dm_data_out),
    .err_addr   (err_addr)
  );

  // DMEM with combinational read and clocked write
  logic [31:0] dmem [32];
  assign dm_data_out = dmem[dm_addr];
  always @(posedge clk_in) if (dm_ena && dm_wena) dmem[dm_addr] <= dm_data_in;

  // Count master-1 grant cycles
  int g1_cnt = 0;
  always @(negedge clk_in) if (m1_gnt) g1_cnt++;

  // Reference model: owner (0 none, 1 m0, 2 m1), denial run, memory image
  int          own, deny;
  logic [31:0] ref_mem [32];
  logic        rv0, rv1, err;
  logic [31:0] rd0, rd1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return RC_EN && ((a < BASE) || ((off / 4) >= 32) || ((a % 4) != 0));
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % 32);
  endfunction

  // Check this cycle's outputs, then advance the model across the next edge
  task automatic step();
    logic        q0, q1, r, we, bad;
    logic [31:0] a, wd;
    int          idx;
    #1;
    we  = (own == 2) ? m1_wena  : m0_wena;
    a   = (own == 2) ? m1_addr  : m0_addr;
    wd  = (own == 2) ? m1_wdata : m0_wdata;
    bad = (own != 0) && is_oor(a);
    idx = word_idx(a);
    chk("m0_gnt",     32'(m0_gnt),     32'(own == 1));
    chk("m1_gnt",     32'(m1_gnt),     32'(own == 2));
    chk("dm_ena",     32'(dm_ena),     32'((own != 0) && !bad));
    chk("dm_wena",    32'(dm_wena),    32'((own != 0) && !bad && we));
    chk("dm_addr",    32'(dm_addr),    (own != 0) ? 32'(idx) : 32'd0);
    chk("dm_data_in", dm_data_in,      (own != 0) ? wd : 32'd0);
    chk("m0_rvalid",  32'(m0_rvalid),  32'(rv0));
    chk("m1_rvalid",  32'(m1_rvalid),  32'(rv1));
    chk("m0_rdata",   m0_rdata,        rd0);
    chk("m1_rdata",   m1_rdata,        rd1);
    chk("err_addr",   32'(err_addr),   32'(err));
    q0 = m0_req;
    q1 = m1_req;
    r  = reset;
    @(posedge clk_in);
    rv0 = 1'b0;
    rv1 = 1'b0;
    if (own != 0) begin
      if (we) begin
        if (!bad) ref_mem[idx] = wd;
      end else if (own == 1) begin
        rv0 = 1'b1;
        rd0 = bad ? 32'h0 : ref_mem[idx];
      end else begin
        rv1 = 1'b1;
        rd1 = bad ? 32'h0 : ref_mem[idx];
      end
      if (bad) err = 1'b1;
    end
    if (r) begin
      own = 0; deny = 0; rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0; err = 0;
    end else begin
      if (q1 && deny == MAXS)  own = 2;
      else if (q0)             own = 1;
      else if (q1)             own = 2;
      else                     own = 0;
      deny = (q1 && own != 2) ? ((deny < MAXS) ? deny + 1 : MAXS) : 0;
    end
    #1;
  endtask

  // Single-master access: request for one cycle, hold fields through the grant
  task automatic xfer(input int m, input logic we, input logic [31:0] a, input logic [31:0] wd);
    if (m == 0) begin m0_req = 1; m0_wena = we; m0_addr = a; m0_wdata = wd; end
    else        begin m1_req = 1; m1_wena = we; m1_addr = a; m1_wdata = wd; end
    step();
    if (m == 0) m0_req = 0; else m1_req = 0;
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return $urandom;
    if (k == 1) return BASE + 32'($urandom_range(0, 159));
    return BASE + 32'($urandom_range(0, 31)) * 32'd4;
  endfunction

  initial begin
    int g_before;
    reset = 1; m0_req = 0; m0_wena = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wena = 0; m1_addr = 0; m1_wdata = 0;
    own = 0; deny = 0; rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0; err = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    repeat (2) @(posedge clk_in);
    #1;
    step();
    reset = 0;
    step();

    // m1 fills every word back to back
    g_before = g1_cnt;
    m1_req = 1; m1_wena = 1; m1_addr = BASE; m1_wdata = 32'hA500_0000;
    step();
    for (int i = 0; i < 32; i++) begin
      m1_addr  = BASE + 32'(i) * 32'd4;
      m1_wdata = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
      m1_req   = (i != 31);
      step();
    end
    step();
    chk("fill_gnt_count", 32'(g1_cnt - g_before), 32'd32);

    // m0 write of 0x10010008
    m0_req = 1; m0_wena = 1; m0_addr = 32'h1001_0008; m0_wdata = 32'hDEAD_BEEF;
    step();
    m0_req = 0;
    chk("wr_gnt", 32'(m0_gnt), 32'd1);
    chk("wr_addr", 32'(dm_addr), 32'd2);
    chk("wr_data", dm_data_in, 32'hDEAD_BEEF);
    step();

    // m0 readback of the same word, then hold
    xfer(0, 1'b0, 32'h1001_0008, 32'h0);
    chk("rd_rvalid", 32'(m0_rvalid), 32'd1);
    step();
    step();
    chk("rd_hold", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_rvalid_drop", 32'(m0_rvalid), 32'd0);

    // m0 reads back the fill
    for (int k = 0; k < 32; k++) xfer(0, 1'b0, BASE + 32'(k) * 32'd4, 32'h0);
    step();

    // Continuous contention: four m0 grants then one forced m1 grant
    g_before = g1_cnt;
    m0_req = 1; m0_wena = 0; m0_addr = BASE + 32'd4;
    m1_req = 1; m1_wena = 0; m1_addr = BASE + 32'd8;
    repeat (21) step();
    chk("starve_g1_count", 32'(g1_cnt - g_before), 32'd4);
    m0_req = 0; m1_req = 0;
    step();
    step();

    // Reset during an m1 read-grant cycle
    m1_req = 1; m1_wena = 0; m1_addr = BASE + 32'd12;
    step();
    chk("rst_in_gnt", 32'(m1_gnt), 32'd1);
    reset = 1; m1_req = 0;
    step();
    reset = 0;
    chk("rst_gnt_drop", 32'(m1_gnt), 32'd0);
    chk("rst_no_rvalid", 32'(m1_rvalid), 32'd0);
    step();
    chk("rst_no_rvalid_late", 32'(m1_rvalid), 32'd0);
    step();

    // Read one word past the end of DMEM
    m0_req = 1; m0_wena = 0; m0_addr = 32'h1001_0080;
    step();
    m0_req = 0;
    chk("oor_gnt", 32'(m0_gnt), 32'd1);
    chk("oor_dm_ena", 32'(dm_ena), RC_EN ? 32'd0 : 32'd1);
    chk("oor_dm_addr", 32'(dm_addr), 32'd0);
    step();
    step();
    chk("oor_err", 32'(err_addr), 32'(RC_EN));
    step();

    // Random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      reset    = ($urandom_range(0, 63) == 0);
      m0_req   = ($urandom_range(0, 2) != 0);
      m1_req   = ($urandom_range(0, 2) != 0);
      m0_wena  = 1'($urandom_range(0, 1));
      m1_wena  = 1'($urandom_range(0, 1));
      m0_addr  = rand_addr();
      m1_addr  = rand_addr();
      m0_wdata = $urandom;
      m1_wdata = $urandom;
      step();
    end
    reset = 1; m0_req = 0; m1_req = 0;
    step();
    reset = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
